mp_dcache_tag_lookup: RTL
=========================

Name: mp_dcache_tag_lookup

Overview:
Tag-lookup stage of the data cache. It sits directly in front of the 16x24 single-port tag SRAM macro and consumes its read data. It accepts lookup requests from the cache controller, drives the SRAM read, and one cycle later compares the stored tag against the request to report hit, dirty and victim tag. It also serialises tag updates (fill, set-dirty, invalidate) into SRAM writes and holds the per-set valid bits in flops, because the SRAM has no reset.

Parameters:
ADDR_WIDTH, 32, request address width
OFFSET_BITS, 5, byte offset within a 32 B line
INDEX_BITS, 4, set index width (16 sets; matches the SRAM depth)
TAG_BITS, 23, ADDR_WIDTH-INDEX_BITS-OFFSET_BITS
TAG_WORD, 24, SRAM word: [23] dirty, [22:0] tag

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  lookup request
req_ready  out  1  request accepted when valid&ready
req_addr  in  ADDR_WIDTH  lookup address
rsp_valid  out  1  lookup result valid
rsp_ready  in  1  downstream accepts result
rsp_hit  out  1  valid[idx] && stored tag == request tag
rsp_dirty  out  1  stored dirty bit, gated by valid[idx]
rsp_victim_tag  out  TAG_BITS  stored tag, for writeback address
rsp_index  out  INDEX_BITS  index of the responding request
upd_valid  in  1  tag update command
upd_ready  out  1  update accepted when valid&ready
upd_op  in  2  0 FILL, 1 SET_DIRTY, 2 INVALIDATE, 3 reserved (no-op, still consumed)
upd_index  in  INDEX_BITS  target set
upd_tag  in  TAG_BITS  tag to write (FILL and SET_DIRTY)
upd_dirty  in  1  dirty value for FILL
tag_csb0  out  1  SRAM chip select, active low
tag_web0  out  1  SRAM write enable, active low
tag_addr0  out  INDEX_BITS  SRAM address
tag_din0  out  TAG_WORD  SRAM write data
tag_dout0  in  TAG_WORD  SRAM read data; valid from the negedge after issue until the next posedge + hold

Behaviour:
- All inputs are sampled at posedge clk. Reset is synchronous and active-high (rst).
- Reset values:
  - s1 state = EMPTY; valid[15:0] = 0.
  - req_ready = 0 and upd_ready = 0 during reset.
  - rsp_valid = 0, rsp_hit = 0, rsp_dirty = 0, rsp_victim_tag = 0, rsp_index = 0.
  - tag_csb0 = 1, tag_web0 = 1, tag_addr0 = 0, tag_din0 = 0.
- SRAM port outputs are registered, launched at the posedge that accepts a command.
- Stage-1 FSM states:
  - EMPTY: no response pending.
  - LOOKUP: response driven combinationally from tag_dout0 and registered request tag/index. This is the cycle after acceptance, so latency is 1.
  - HOLD: response driven from capture registers.
- Transitions:
  - EMPTY -> LOOKUP on request accept.
  - LOOKUP, rsp_ready=1: -> LOOKUP if a new request is accepted the same cycle, else -> EMPTY.
  - LOOKUP, rsp_ready=0: capture hit/dirty/victim/index, -> HOLD.
  - HOLD, rsp_ready=1: -> LOOKUP if a new request is accepted, else -> EMPTY.
- Outputs are stable throughout HOLD; the SRAM dout going X does not affect them.
- Ready logic:
  - Stage-1 free condition: s1 == EMPTY or rsp_ready = 1.
  - upd_ready = stage-1 free.
  - req_ready = stage-1 free && !upd_valid. Updates have strict priority, so at most one SRAM access is issued per cycle.
- Update execution (write issued in the accept cycle):
  - FILL: writes {upd_dirty, upd_tag}; valid[idx] <= 1.
  - SET_DIRTY: writes {1, upd_tag}; valid unchanged.
  - INVALIDATE: no SRAM access; valid[idx] <= 0.
- A request accepted in the cycle after an update to the same index sees the updated tag and valid bit. No extra bubble is needed because the SRAM writes at negedge.
- Hit compare is an exact TAG_BITS equality. A miss with valid[idx] = 0 reports rsp_dirty = 0.
- Reset mid-operation (in LOOKUP or HOLD) drops the pending response. rsp_valid is 0 in the cycle after rst is sampled, and no SRAM write is issued.
- tag_csb0 = 1 in every cycle with no accepted command. tag_din0 is don't-care on reads.

Decomposition:
- Shared package mp_dcache_pkg:
  - constants OFFSET_BITS, INDEX_BITS, TAG_BITS, TAG_WORD, DIRTY_BIT = 23;
  - upd_op_t enum {FILL, SET_DIRTY, INVALIDATE};
  - s1_state_t enum {EMPTY, LOOKUP, HOLD};
  - tag_word_t packed struct {dirty, tag}.
- One natural sub-module, mp_dcache_valid_array: the 16-bit flop array with set/clear/read ports and synchronous reset.

Test Plan:
- Reset, then request addr 0x02468A60 (tag 0x012345, idx 3) -> rsp_valid one cycle after accept, rsp_hit = 0, rsp_dirty = 0, rsp_index = 3.
- FILL idx 3, tag 0x012345, dirty 0; next cycle request 0x02468A60 -> rsp_hit = 1, rsp_dirty = 0. Request with tag 0x000001, idx 3 -> hit = 0, rsp_victim_tag = 0x012345.
- Backpressure: hit response with rsp_ready = 0 for 3 cycles -> rsp_hit/rsp_victim_tag/rsp_index unchanged across all 3 cycles, req_ready = 0, tag_csb0 = 1. Then rsp_ready = 1 -> consumed and a new request is accepted the same cycle.
- SET_DIRTY idx 3 tag 0x012345, then lookup -> hit = 1, dirty = 1. INVALIDATE idx 3, then lookup -> hit = 0, dirty = 0, and no SRAM write is observed for the INVALIDATE.
- upd_valid and req_valid in the same cycle -> upd accepted, req_ready = 0, tag_web0 = 0. Request accepted the next cycle with tag_web0 = 1.
- Assert rst while in HOLD -> rsp_valid = 0 the next cycle, all valid bits 0, and a subsequent lookup of a previously filled set misses.

Source files
------------

// File: rtl/mp_dcache_pkg.sv
// Shared definitions for the data-cache tag-lookup slice: geometry constants,
// update opcodes, stage-1 states and the tag SRAM word layout.
package mp_dcache_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned INDEX_BITS  = 4;
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned TAG_WORD    = TAG_BITS + 1;
    localparam int unsigned DIRTY_BIT   = 23;
    localparam int unsigned NUM_SETS    = 1 << INDEX_BITS;

    // Encoding 2'd3 is reserved: consumed as a no-op.
    typedef enum logic [1:0] {
        FILL       = 2'd0,
        SET_DIRTY  = 2'd1,
        INVALIDATE = 2'd2
    } upd_op_t;

    typedef enum logic [1:0] {
        EMPTY,
        LOOKUP,
        HOLD
    } s1_state_t;

    // Bit DIRTY_BIT of the SRAM word is the dirty flag, the rest is the tag.
    typedef struct packed {
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
    } tag_word_t;

endpackage

// File: rtl/mp_dcache_valid_array.sv
// Per-set valid bits kept in flops, since the tag SRAM itself has no reset.
module mp_dcache_valid_array
    import mp_dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [INDEX_BITS-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [INDEX_BITS-1:0] clr_idx,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid
);

    logic [NUM_SETS-1:0] valid_q;

    // Valid flops: cleared on reset, set by fills, cleared by invalidates.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (set_en) valid_q[set_idx] <= 1'b1;
            if (clr_en) valid_q[clr_idx] <= 1'b0;
        end
    end

    // Asynchronous read of the addressed set.
    always_comb begin
        rd_valid = valid_q[rd_idx];
    end

endmodule

// File: rtl/mp_dcache_tag_lookup.sv
// Tag-lookup stage of the data cache: issues tag SRAM reads for lookups,
// compares one cycle later, and serialises tag updates into SRAM writes.
module mp_dcache_tag_lookup
    import mp_dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_dirty,
    output logic [TAG_BITS-1:0]   rsp_victim_tag,
    output logic [INDEX_BITS-1:0] rsp_index,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [1:0]            upd_op,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [TAG_BITS-1:0]   upd_tag,
    input  logic                  upd_dirty,
    output logic                  tag_csb0,
    output logic                  tag_web0,
    output logic [INDEX_BITS-1:0] tag_addr0,
    output logic [TAG_WORD-1:0]   tag_din0,
    input  logic [TAG_WORD-1:0]   tag_dout0
);

    s1_state_t             state_q, state_d;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic [INDEX_BITS-1:0] req_idx_q;
    logic                  cap_hit_q, cap_dirty_q;
    logic [TAG_BITS-1:0]   cap_victim_q;
    logic [INDEX_BITS-1:0] cap_idx_q;

    logic                  s1_free;
    logic                  upd_fire, req_fire, upd_wr, fill_fire, inval_fire;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic                  unused_offset;
    tag_word_t             rd_word, wr_word;
    logic                  lk_valid, lk_hit, lk_dirty;

    assign req_tag       = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx       = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

    // Handshake: updates win over lookups so only one SRAM access per cycle.
    always_comb begin
        s1_free    = (state_q == EMPTY) || rsp_ready;
        upd_ready  = s1_free && !rst;
        req_ready  = s1_free && !upd_valid && !rst;
        upd_fire   = upd_valid && upd_ready;
        req_fire   = req_valid && req_ready;
        fill_fire  = upd_fire && (upd_op == FILL);
        inval_fire = upd_fire && (upd_op == INVALIDATE);
        upd_wr     = fill_fire || (upd_fire && (upd_op == SET_DIRTY));
        wr_word.tag   = upd_tag;
        wr_word.dirty = (upd_op == FILL) ? upd_dirty : 1'b1;
    end

    mp_dcache_valid_array u_valid (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fill_fire),
        .set_idx  (upd_index),
        .clr_en   (inval_fire),
        .clr_idx  (upd_index),
        .rd_idx   (req_idx_q),
        .rd_valid (lk_valid)
    );

    // Compare the word read last cycle against the registered request.
    always_comb begin
        rd_word  = tag_dout0;
        lk_hit   = lk_valid && (rd_word.tag == req_tag_q);
        lk_dirty = lk_valid && rd_word.dirty;
    end

    // SRAM port registers, launched at the edge that accepts a command.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_csb0  <= 1'b1;
            tag_web0  <= 1'b1;
            tag_addr0 <= '0;
            tag_din0  <= '0;
        end else if (upd_wr) begin
            tag_csb0  <= 1'b0;
            tag_web0  <= 1'b0;
            tag_addr0 <= upd_index;
            tag_din0  <= wr_word;
        end else if (req_fire) begin
            tag_csb0  <= 1'b0;
            tag_web0  <= 1'b1;
            tag_addr0 <= req_idx;
        end else begin
            tag_csb0  <= 1'b1;
            tag_web0  <= 1'b1;
        end
    end

    // Request tag/index held for the compare cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag_q <= '0;
            req_idx_q <= '0;
        end else if (req_fire) begin
            req_tag_q <= req_tag;
            req_idx_q <= req_idx;
        end
    end

    // Capture the result when a stalled lookup moves to HOLD, since the SRAM
    // output is only valid during the compare cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_hit_q    <= 1'b0;
            cap_dirty_q  <= 1'b0;
            cap_victim_q <= '0;
            cap_idx_q    <= '0;
        end else if (state_q == LOOKUP && !rsp_ready) begin
            cap_hit_q    <= lk_hit;
            cap_dirty_q  <= lk_dirty;
            cap_victim_q <= rd_word.tag;
            cap_idx_q    <= req_idx_q;
        end
    end

    // Stage-1 state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Stage-1 next state and response outputs.
    always_comb begin
        state_d        = state_q;
        rsp_valid      = 1'b0;
        rsp_hit        = 1'b0;
        rsp_dirty      = 1'b0;
        rsp_victim_tag = '0;
        rsp_index      = '0;
        case (state_q)
            EMPTY: begin
                if (req_fire) state_d = LOOKUP;
            end
            LOOKUP: begin
                rsp_valid      = 1'b1;
                rsp_hit        = lk_hit;
                rsp_dirty      = lk_dirty;
                rsp_victim_tag = rd_word.tag;
                rsp_index      = req_idx_q;
                if (rsp_ready) state_d = req_fire ? LOOKUP : EMPTY;
                else           state_d = HOLD;
            end
            HOLD: begin
                rsp_valid      = 1'b1;
                rsp_hit        = cap_hit_q;
                rsp_dirty      = cap_dirty_q;
                rsp_victim_tag = cap_victim_q;
                rsp_index      = cap_idx_q;
                if (rsp_ready) state_d = req_fire ? LOOKUP : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule
